// File: rtl/dotseq_pkg.sv
// Shared types and helpers for the dot-product sequencer.
package dotseq_pkg;

  localparam int DOTSEQ_ELEM_BYTES = 3;
  localparam int EW                = DOTSEQ_ELEM_BYTES * 8;
  localparam int PROD_W            = 2 * EW;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_B = 3'd2,
    ACCUM   = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5
  } dotseq_state_e;

  // Lengths are legal when they match and both vectors fit in the RAM
  // (B occupies N..2N-1, so 2N must not exceed the address space).
  function automatic logic len_legal(input logic [63:0] fl,
                                     input logic [63:0] sl,
                                     input int          aw);
    logic [64:0] two_n;
    logic [64:0] lim;
    two_n = {fl, 1'b0};
    lim   = 65'd1 << aw;
    return (fl == sl) && (two_n <= lim);
  endfunction

endpackage

// File: rtl/dot_product_sequencer_if.sv
// Vector RAM read port: sequencer is master, RAM is slave.
interface dot_product_sequencer_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 24
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/dotseq_mac.sv
// Multiply-accumulate: holds A operand, multiplies by incoming B, accumulates.
// DOTSEQ_SATURATE_EN selects clamp-on-carry with sticky overflow; otherwise wrap.
module dotseq_mac #(
  parameter int EW        = 24,
  parameter int ACC_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 load_a,
  input  logic                 acc_en,
  input  logic [EW-1:0]        din,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 overflow
);

  logic [EW-1:0]        a_d, a_q;
  logic [ACC_WIDTH-1:0] acc_d, acc_q;
  logic [2*EW-1:0]      prod;
  logic [ACC_WIDTH-1:0] prod_ext;

  assign prod     = {{EW{1'b0}}, a_q} * {{EW{1'b0}}, din};
  assign prod_ext = ACC_WIDTH'(prod);
  assign acc      = acc_q;

`ifdef DOTSEQ_SATURATE_EN
  logic              ovf_d, ovf_q;
  logic [ACC_WIDTH:0] sum;

  assign sum      = {1'b0, acc_q} + {1'b0, prod_ext};
  assign overflow = ovf_q;

  // Next-state: clear on new op, latch A, accumulate with clamp on carry-out.
  always_comb begin
    a_d   = a_q;
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (load_a) a_d = din;
      if (acc_en) begin
        if (sum[ACC_WIDTH]) begin
          acc_d = '1;
          ovf_d = 1'b1;
        end else begin
          acc_d = sum[ACC_WIDTH-1:0];
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end
`else
  assign overflow = 1'b0;

  // Next-state: clear on new op, latch A, accumulate modulo 2^ACC_WIDTH.
  always_comb begin
    a_d   = a_q;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else begin
      if (load_a) a_d = din;
      if (acc_en) acc_d = acc_q + prod_ext;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      acc_q <= acc_d;
    end
  end
`endif

endmodule

// File: rtl/dot_product_sequencer.sv
// Dot-product sequencer: walks the shared vector RAM (A at i, B at N+i),
// feeding the MAC three cycles per element. All outputs are registered.
// Optional saturation: define DOTSEQ_SATURATE_EN.
module dot_product_sequencer
  import dotseq_pkg::*;
#(
  parameter int ELEMENT_WIDTH = DOTSEQ_ELEM_BYTES,
  parameter int ADDR_WIDTH    = 17,
  parameter int ACC_WIDTH     = 64,
  localparam int EWL          = ELEMENT_WIDTH * 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [EWL-1:0]           first_len,
  input  logic [EWL-1:0]           second_len,
  dot_product_sequencer_if.master  ram,
  output logic                     busy,
  output logic [ACC_WIDTH-1:0]     result,
  output logic                     result_valid,
  output logic                     error,
  output logic                     overflow
);

  dotseq_state_e         state_d, state_q;
  logic [EWL-1:0]        idx_d, idx_q;
  logic [EWL-1:0]        n_d, n_q;
  logic                  rd_en_d, rd_en_q;
  logic [ADDR_WIDTH-1:0] rd_addr_d, rd_addr_q;
  logic                  busy_d, busy_q;
  logic                  rv_d, rv_q;
  logic                  err_d, err_q;
  logic                  clr, load_a, acc_en;

  assign ram.rd_en    = rd_en_q;
  assign ram.rd_addr  = rd_addr_q;
  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign error        = err_q;

  // Next-state and registered-output decode; outputs follow the next state
  // so each strobe lines up with the state it belongs to.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    clr     = 1'b0;
    load_a  = 1'b0;
    acc_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d   = first_len;
          idx_d = '0;
          clr   = 1'b1;
          if (!len_legal(64'(first_len), 64'(second_len), ADDR_WIDTH))
            state_d = ERR;
          else if (first_len == '0)
            state_d = DONE;
          else
            state_d = FETCH_A;
        end
      end
      FETCH_A: state_d = FETCH_B;
      FETCH_B: begin
        load_a  = 1'b1;
        state_d = ACCUM;
      end
      ACCUM: begin
        acc_en = 1'b1;
        idx_d  = idx_q + 1'b1;
        if (({1'b0, idx_q} + 1'b1) < {1'b0, n_q})
          state_d = FETCH_A;
        else
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rd_en_d   = (state_d == FETCH_A) || (state_d == FETCH_B);
    rd_addr_d = rd_addr_q;
    if (state_d == FETCH_A)
      rd_addr_d = ADDR_WIDTH'(idx_d);
    else if (state_d == FETCH_B)
      rd_addr_d = ADDR_WIDTH'({1'b0, n_d} + {1'b0, idx_d});
    busy_d = (state_d != IDLE);
    rv_d   = (state_d == DONE);
    err_d  = (state_d == ERR);
  end

  // FSM, index and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      n_q       <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      rv_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      n_q       <= n_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      rv_q      <= rv_d;
      err_q     <= err_d;
    end
  end

  dotseq_mac #(.EW(EWL), .ACC_WIDTH(ACC_WIDTH)) u_mac (
    .clk      (clk),
    .rst_n    (reset),
    .clr      (clr),
    .load_a   (load_a),
    .acc_en   (acc_en),
    .din      (ram.rd_data),
    .acc      (result),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer with a synchronous-read RAM model.
module tb_dot_product_sequencer;

  localparam int AW  = 6;
  localparam int EW  = 24;
  localparam int ACW = 48;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [EW-1:0]  first_len, second_len;
  logic           busy, result_valid, error, overflow;
  logic [ACW-1:0] result;

  logic [EW-1:0]  mem [0:(1<<AW)-1];

  int n_chk = 0;
  int n_bad = 0;

  // per-run observations
  int       rv_cyc, rv_cnt, err_cyc, err_cnt, rd_cnt;
  int       addrs[$];
  bit       busy_log [0:127];

  dot_product_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(EW)) ram_if ();

  dot_product_sequencer #(.ELEMENT_WIDTH(3), .ADDR_WIDTH(AW), .ACC_WIDTH(ACW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .first_len    (first_len),
    .second_len   (second_len),
    .ram          (ram_if.master),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .error        (error),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  initial ram_if.rd_data = '0;
  always @(posedge clk) if (ram_if.rd_en) ram_if.rd_data <= mem[ram_if.rd_addr];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // Issue start with the given lengths, observe ncyc cycles after the sampled one.
  // poke_at: cycle to pulse start again; rst_at: cycle to assert reset.
  task automatic run(input logic [EW-1:0] fl, input logic [EW-1:0] sl,
                     input int poke_at, input int rst_at, input int ncyc);
    rv_cyc = -1; rv_cnt = 0; err_cyc = -1; err_cnt = 0; rd_cnt = 0;
    addrs.delete();
    for (int i = 0; i < 128; i++) busy_log[i] = 1'b0;
    @(negedge clk);
    start = 1'b1; first_len = fl; second_len = sl;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (ram_if.rd_en) begin rd_cnt++; addrs.push_back(int'(ram_if.rd_addr)); end
      if (result_valid) begin rv_cnt++; if (rv_cyc < 0) rv_cyc = c; end
      if (error) begin err_cnt++; if (err_cyc < 0) err_cyc = c; end
      busy_log[c] = busy;
      start = (c == poke_at);
      if (c == rst_at) begin
        reset = 1'b0;
        #1;
        chk("rst_mid_busy",   64'(busy), 0);
        chk("rst_mid_rd_en",  64'(ram_if.rd_en), 0);
        chk("rst_mid_addr",   64'(ram_if.rd_addr), 0);
        chk("rst_mid_result", 64'(result), 0);
        chk("rst_mid_rv",     64'(result_valid), 0);
      end
      @(negedge clk);
    end
    start = 1'b0;
    reset = 1'b1;
  endtask

  task automatic load_abc;
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    mem[0] = 1; mem[1] = 2; mem[2] = 3;
    mem[3] = 4; mem[4] = 5; mem[5] = 6;
  endtask

  initial begin
    int exp_addr;
    reset = 1'b0; start = 1'b0; first_len = '0; second_len = '0;
    load_abc();
    repeat (3) @(negedge clk);
    chk("rst_busy",   64'(busy), 0);
    chk("rst_rd_en",  64'(ram_if.rd_en), 0);
    chk("rst_addr",   64'(ram_if.rd_addr), 0);
    chk("rst_result", 64'(result), 0);
    chk("rst_rv",     64'(result_valid), 0);
    chk("rst_err",    64'(error), 0);
    chk("rst_ovf",    64'(overflow), 0);
    reset = 1'b1;
    @(negedge clk);

    // A=[1,2,3] B=[4,5,6]
    run(3, 3, -1, -1, 14);
    chk("n3_rd_cnt", 64'(rd_cnt), 6);
    for (int i = 0; i < 6; i++) begin
      exp_addr = (i % 2 == 0) ? i / 2 : 3 + i / 2;
      chk($sformatf("n3_addr%0d", i), 64'(addrs[i]), 64'(exp_addr));
    end
    chk("n3_rv_cyc", 64'(rv_cyc), 10);
    chk("n3_rv_cnt", 64'(rv_cnt), 1);
    chk("n3_result", 64'(result), 32);
    chk("n3_busy1",  64'(busy_log[1]), 1);
    chk("n3_busy10", 64'(busy_log[10]), 1);
    chk("n3_busy11", 64'(busy_log[11]), 0);
    chk("n3_ovf",    64'(overflow), 0);

    // empty vectors
    run(0, 0, -1, -1, 4);
    chk("n0_rv_cyc", 64'(rv_cyc), 1);
    chk("n0_rv_cnt", 64'(rv_cnt), 1);
    chk("n0_result", 64'(result), 0);
    chk("n0_rd_cnt", 64'(rd_cnt), 0);
    chk("n0_busy2",  64'(busy_log[2]), 0);

    // restore a nonzero result so the error run must clear it
    run(3, 3, -1, -1, 12);
    chk("n3b_result", 64'(result), 32);

    // length mismatch
    run(3, 4, -1, -1, 5);
    chk("mm_err_cyc", 64'(err_cyc), 1);
    chk("mm_err_cnt", 64'(err_cnt), 1);
    chk("mm_result",  64'(result), 0);
    chk("mm_busy1",   64'(busy_log[1]), 1);
    chk("mm_busy2",   64'(busy_log[2]), 0);
    chk("mm_rd_cnt",  64'(rd_cnt), 0);
    chk("mm_rv_cnt",  64'(rv_cnt), 0);

    // A=[7,0,255,1000] B=[3,9,2,5] -> 21+0+510+5000
    mem[0] = 7; mem[1] = 0; mem[2] = 255; mem[3] = 1000;
    mem[4] = 3; mem[5] = 9; mem[6] = 2;   mem[7] = 5;
    run(4, 4, -1, -1, 16);
    chk("n4_rv_cyc", 64'(rv_cyc), 13);
    chk("n4_result", 64'(result), 5531);
    chk("n4_last_addr", 64'(addrs[7]), 7);

    // all-ones operands, two elements: carries out of 48 bits
    for (int i = 0; i < 4; i++) mem[i] = 24'hFFFFFF;
    run(2, 2, -1, -1, 9);
    chk("sat_rv_cyc", 64'(rv_cyc), 7);
`ifdef DOTSEQ_SATURATE_EN
    chk("sat_result", 64'(result), 64'hFFFF_FFFF_FFFF);
    chk("sat_ovf",    64'(overflow), 1);
`else
    chk("wrap_result", 64'(result), 64'hFFFF_FC00_0002);
    chk("wrap_ovf",    64'(overflow), 0);
`endif

    // start pulsed mid-run is ignored; overflow cleared by the new op
    load_abc();
    run(3, 3, 4, -1, 16);
    chk("poke_rv_cyc", 64'(rv_cyc), 10);
    chk("poke_rv_cnt", 64'(rv_cnt), 1);
    chk("poke_result", 64'(result), 32);
    chk("poke_ovf",    64'(overflow), 0);

    // reset mid-run aborts, then a fresh run still works
    run(3, 3, -1, 5, 14);
    chk("rst_rv_cnt", 64'(rv_cnt), 0);
    run(3, 3, -1, -1, 12);
    chk("post_rst_rv_cyc", 64'(rv_cyc), 10);
    chk("post_rst_result", 64'(result), 32);

    // largest legal N fills the RAM: A[i]=i+1, B[i]=1
    for (int i = 0; i < 32; i++) begin mem[i] = EW'(i + 1); mem[32 + i] = 1; end
    run(32, 32, -1, -1, 100);
    chk("max_rd_cnt",   64'(rd_cnt), 64);
    chk("max_last_addr", 64'(addrs[63]), 63);
    chk("max_rv_cyc",   64'(rv_cyc), 97);
    chk("max_result",   64'(result), 528);

    // one past the limit: 2N exceeds the address space
    run(33, 33, -1, -1, 4);
    chk("big_err_cyc", 64'(err_cyc), 1);
    chk("big_rd_cnt",  64'(rd_cnt), 0);
    chk("big_result",  64'(result), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
